// File: rtl/hdlc_pkg.sv
// rtl/hdlc_pkg.sv - shared HDLC link constants and receiver state type
package hdlc_pkg;

   localparam int          HDLC_WORD_W    = 16;
   localparam int          HDLC_STUFF_RUN = 5;
   localparam int          HDLC_ABORT_RUN = 7;
   localparam logic [7:0]  HDLC_FLAG      = 8'h7E;

   typedef enum logic {
      HUNT = 1'b0,
      SYNC = 1'b1
   } hdlc_state_t;

endpackage

// File: rtl/hdlc_destuffer.sv
// rtl/hdlc_destuffer.sv - raw bit window, ones run tracking, flag/abort/stuffed-zero detection
module hdlc_destuffer
   import hdlc_pkg::*;
#(
   parameter int STUFF_RUN = HDLC_STUFF_RUN,
   parameter int ABORT_RUN = HDLC_ABORT_RUN
)
(
   input  logic clk,
   input  logic reset,
   input  logic serin,
   output logic flag_hit,
   output logic abort_hit,
   output logic bit_out,
   output logic bit_keep
);

   localparam int OW = $clog2(ABORT_RUN + 1);

   logic [7:0]    win, win_next;
   logic [OW-1:0] ones, ones_next;
   logic          drop;

   always_comb begin
      win_next = {serin, win[7:1]};
      if (!serin)
         ones_next = '0;
      else if (ones == OW'(ABORT_RUN))
         ones_next = ones;
      else
         ones_next = ones + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win  <= '0;
         ones <= '0;
      end else begin
         win  <= win_next;
         ones <= ones_next;
      end
   end

   // a flag's zero follows six ones, so it can never look like a stuffed zero
   assign flag_hit  = (win_next == HDLC_FLAG);
   assign abort_hit = serin && (ones == OW'(ABORT_RUN - 1));
   assign drop      = !serin && (ones == OW'(STUFF_RUN));
   assign bit_out   = serin;
   assign bit_keep  = !drop;

endmodule

// File: rtl/hdlc_inputregister.sv
// rtl/hdlc_inputregister.sv - HDLC serial receive register: flag alignment and word assembly
module hdlc_inputregister
   import hdlc_pkg::*;
#(
   parameter int WORD_W    = HDLC_WORD_W,
   parameter int STUFF_RUN = HDLC_STUFF_RUN,
   parameter int ABORT_RUN = HDLC_ABORT_RUN
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              serin,
   output logic [WORD_W-1:0] data_out,
   output logic              data_out_isCTL,
   output logic              data_valid,
   output logic              in_sync,
   output logic              abort
);

   localparam int CW = $clog2(WORD_W + 1);

   hdlc_state_t       state, state_next;
   logic [CW-1:0]     cnt, cnt_n, cnt_inc;
   logic [WORD_W-1:0] word, word_n, shifted, dout_n;
   logic              fseen, fseen_n, ctl_n, valid_n, abort_n;
   logic              flag_hit, abort_hit, bit_out, bit_keep;

   hdlc_destuffer #(
      .STUFF_RUN (STUFF_RUN),
      .ABORT_RUN (ABORT_RUN)
   ) u_destuffer (
      .clk       (clk),
      .reset     (reset),
      .serin     (serin),
      .flag_hit  (flag_hit),
      .abort_hit (abort_hit),
      .bit_out   (bit_out),
      .bit_keep  (bit_keep)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= HUNT;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         HUNT: if (flag_hit)  state_next = SYNC;
         SYNC: if (abort_hit) state_next = HUNT;
         default: state_next = HUNT;
      endcase
   end

   always_comb begin
      cnt_n   = cnt;
      word_n  = word;
      fseen_n = fseen;
      dout_n  = data_out;
      ctl_n   = data_out_isCTL;
      valid_n = 1'b0;
      abort_n = 1'b0;
      cnt_inc = cnt + 1'b1;
      shifted = {bit_out, word[WORD_W-1:1]};
      case (state)
         HUNT: begin
            if (flag_hit) begin
               cnt_n                = CW'(8);
               word_n[WORD_W-1 -: 8] = HDLC_FLAG;
               fseen_n              = 1'b1;
            end
         end
         SYNC: begin
            if (abort_hit) begin
               cnt_n   = '0;
               fseen_n = 1'b0;
               abort_n = 1'b1;
            end else if (bit_keep) begin
               word_n = shifted;
               cnt_n  = cnt_inc;
               if (cnt_inc == CW'(WORD_W)) begin
                  dout_n  = shifted;
                  ctl_n   = fseen | flag_hit;
                  valid_n = 1'b1;
                  cnt_n   = '0;
                  fseen_n = 1'b0;
               end else if (flag_hit) begin
                  fseen_n = 1'b1;
                  // a flag off a byte boundary restarts the word with the flag as its first byte
                  if (cnt_inc[2:0] != 3'd0) begin
                     cnt_n                = CW'(8);
                     word_n[WORD_W-1 -: 8] = HDLC_FLAG;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt            <= '0;
         word           <= '0;
         fseen          <= 1'b0;
         data_out       <= '0;
         data_out_isCTL <= 1'b0;
         data_valid     <= 1'b0;
         abort          <= 1'b0;
      end else begin
         cnt            <= cnt_n;
         word           <= word_n;
         fseen          <= fseen_n;
         data_out       <= dout_n;
         data_out_isCTL <= ctl_n;
         data_valid     <= valid_n;
         abort          <= abort_n;
      end
   end

   assign in_sync = (state == SYNC);

endmodule

// File: tb/tb_hdlc_inputregister.sv
// tb/tb_hdlc_inputregister.sv - self-checking bench for hdlc_inputregister
module tb_hdlc_inputregister;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        serin = 1'b0;
   logic [15:0] data_out;
   logic        data_out_isCTL, data_valid, in_sync, abort;

   hdlc_inputregister dut (
      .clk            (clk),
      .reset          (reset),
      .serin          (serin),
      .data_out       (data_out),
      .data_out_isCTL (data_out_isCTL),
      .data_valid     (data_valid),
      .in_sync        (in_sync),
      .abort          (abort)
   );

   always #5 clk = ~clk;

   int tests = 0, failed = 0;
   int cyc = 0;
   bit chk_en = 0;
   int nvalid = 0, nabort = 0, last_cyc = 0, prev_cyc = 0;
   logic [15:0] last_word = '0;
   logic        last_ctl = 0;
   int tx_ones = 0;

   // reference model state: raw bit history and kept bits of the current word
   bit rawq[$];
   bit kq[$];
   bit m_sync, m_fseen;
   logic [15:0] exp_data;
   logic exp_ctl, exp_valid, exp_sync, exp_abort;

   always @(posedge clk) cyc++;

   task automatic model_reset();
      rawq.delete();
      for (int i = 0; i < 8; i++) rawq.push_back(1'b0);
      kq.delete();
      m_sync = 0; m_fseen = 0;
      exp_data = '0; exp_ctl = 0; exp_valid = 0; exp_sync = 0; exp_abort = 0;
   endtask

   task automatic load_flag();
      logic [7:0] f = 8'h7E;
      kq.delete();
      for (int i = 0; i < 8; i++) kq.push_back(f[i]);
   endtask

   task automatic model_bit(input bit b);
      int run = 0;
      logic [7:0] last8;
      bit flag, ab, drop;
      for (int i = rawq.size() - 1; i >= 0 && rawq[i]; i--) run++;
      rawq.push_back(b);
      if (rawq.size() > 16) void'(rawq.pop_front());
      for (int i = 0; i < 8; i++) last8[i] = rawq[rawq.size() - 8 + i];
      flag = (last8 == 8'h7E);
      ab   = b && (run == 6);
      drop = !b && (run == 5);
      exp_valid = 0; exp_abort = 0;
      if (!m_sync) begin
         if (flag) begin m_sync = 1; load_flag(); m_fseen = 1; end
      end else if (ab) begin
         m_sync = 0; exp_abort = 1; kq.delete(); m_fseen = 0;
      end else if (!drop) begin
         kq.push_back(b);
         if (kq.size() == 16) begin
            for (int i = 0; i < 16; i++) exp_data[i] = kq[i];
            exp_ctl = m_fseen | flag; exp_valid = 1;
            kq.delete(); m_fseen = 0;
         end else if (flag) begin
            m_fseen = 1;
            if (kq.size() != 8) load_flag();
         end
      end
      exp_sync = m_sync;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         tests++; if (data_valid !== exp_valid) begin failed++; $display("FAIL cyc%0d data_valid: got %b want %b", cyc, data_valid, exp_valid); end
         tests++; if (abort !== exp_abort) begin failed++; $display("FAIL cyc%0d abort: got %b want %b", cyc, abort, exp_abort); end
         tests++; if (in_sync !== exp_sync) begin failed++; $display("FAIL cyc%0d in_sync: got %b want %b", cyc, in_sync, exp_sync); end
         tests++; if (data_out !== exp_data) begin failed++; $display("FAIL cyc%0d data_out: got %h want %h", cyc, data_out, exp_data); end
         tests++; if (data_out_isCTL !== exp_ctl) begin failed++; $display("FAIL cyc%0d isCTL: got %b want %b", cyc, data_out_isCTL, exp_ctl); end
         if (data_valid === 1'b1) begin
            nvalid++; prev_cyc = last_cyc; last_cyc = cyc; last_word = data_out; last_ctl = data_out_isCTL;
         end
         if (abort === 1'b1) nabort++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin failed++; $display("FAIL %s: got %0h want %0h", name, act, exp); end
   endtask

   task automatic send_bit(input bit b);
      serin = b;
      @(posedge clk);
      model_bit(b);
      tx_ones = b ? tx_ones + 1 : 0;
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1; serin = 0;
      @(posedge clk);
      model_reset();
      chk_en = 1;
      tx_ones = 0;
      @(negedge clk); #1;
      reset = 0;
   endtask

   task automatic send_raw(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) send_bit(v[i]);
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 0; i < 16; i++) begin
         send_bit(w[i]);
         if (tx_ones == 5) send_bit(1'b0);
      end
   endtask

   int v0, a0;

   initial begin
      do_reset();
      chk("reset data_out", data_out, 0);
      chk("reset in_sync", in_sync, 0);

      // 1: idle ones in hunt
      v0 = nvalid; a0 = nabort;
      repeat (40) send_bit(1'b1);
      chk("t1 in_sync", in_sync, 0);
      chk("t1 valids", nvalid - v0, 0);
      chk("t1 aborts", nabort - a0, 0);

      // 2: double flag gives sync then a control word
      send_raw(8'h7E, 7);
      chk("t2 sync before 8th", in_sync, 0);
      send_bit(1'b0);
      chk("t2 sync after 8th", in_sync, 1);
      v0 = nvalid;
      send_raw(8'h7E, 7);
      chk("t2 no early valid", data_valid, 0);
      send_bit(1'b0);
      chk("t2 valid latency", data_valid, 1);
      chk("t2 valids", nvalid - v0, 1);
      chk("t2 word", last_word, 16'h7E7E);
      chk("t2 ctl", last_ctl, 1);

      // 3: single stuffed zero
      v0 = nvalid;
      send_word(16'h001F);
      chk("t3 valids", nvalid - v0, 1);
      chk("t3 word", last_word, 16'h001F);
      chk("t3 ctl", last_ctl, 0);

      // 4: all ones then back-to-back word
      send_word(16'hFFFF);
      chk("t4 word1", last_word, 16'hFFFF);
      chk("t4 ctl1", last_ctl, 0);
      send_word(16'hA5C3);
      chk("t4 word2", last_word, 16'hA5C3);
      chk("t4 spacing", last_cyc - prev_cyc, 16);

      // 5: misaligned flag realigns
      v0 = nvalid;
      send_raw(8'b101, 3);
      send_raw(8'h7E, 8); send_raw(8'h7E, 8);
      chk("t5 valids", nvalid - v0, 1);
      chk("t5 word", last_word, 16'h7E7E);
      chk("t5 ctl", last_ctl, 1);

      // 6: abort mid-word, then reset mid-word
      v0 = nvalid; a0 = nabort;
      send_raw(8'b01010, 5);
      repeat (8) send_bit(1'b1);
      chk("t6 aborts", nabort - a0, 1);
      chk("t6 in_sync", in_sync, 0);
      chk("t6 valids", nvalid - v0, 0);
      send_raw(8'h7E, 8); send_raw(8'h7E, 8);
      send_raw(8'b01010, 5);
      v0 = nvalid;
      do_reset();
      chk("t6 rst data_out", data_out, 0);
      chk("t6 rst in_sync", in_sync, 0);
      chk("t6 rst valid", data_valid, 0);
      repeat (20) send_bit(1'b0);
      chk("t6 no valid after rst", nvalid - v0, 0);

      // randomized traffic against the model
      for (int k = 0; k < 500; k++) begin
         int r = $urandom_range(0, 19);
         logic [15:0] w;
         if (r < 4) send_raw(8'h7E, 8);
         else if (r < 14) begin
            w = 16'($urandom);
            if (r >= 11) w = w | 16'($urandom);
            send_word(w);
         end
         else if (r < 17) send_raw(8'($urandom), $urandom_range(1, 7));
         else if (r < 19) repeat ($urandom_range(6, 10)) send_bit(1'b1);
         else if ($urandom_range(0, 3) == 0) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
